// File: rtl/bus_pkg.sv
// ============================================================
// bus_pkg: shared types and widths for the bus cycle arbiter.
// Revision: 1.0
// ============================================================
`default_nettype none

package bus_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_TW   = 3'd4,
        ST_T4   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MEM_RD = 2'd0,
        MEM_WR = 2'd1,
        IO_RD  = 2'd2,
        IO_WR  = 2'd3
    } cmd_e;

    function automatic logic cmd_is_read(input cmd_e cmd);
        return (cmd == MEM_RD) || (cmd == IO_RD);
    endfunction

    function automatic logic cmd_is_mem(input cmd_e cmd);
        return (cmd == MEM_RD) || (cmd == MEM_WR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================
// rr_arbiter2: two-input round-robin arbiter, pointer moves on grant.
// Revision: 1.0
// ============================================================
`default_nettype none

module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // prio_q = 1 means requester 1 wins a tie
    logic prio_q;
    logic prio_d;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        if (advance && (grant != 2'b00)) begin
            prio_d = grant[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_cycle_arbiter.sv
// ============================================================
// bus_cycle_arbiter: arbitrates two requesters onto a T1-T4 bus cycle.
// Optional macro WAIT_TIMEOUT_EN aborts long wait-state runs.
// Revision: 1.0
// ============================================================
`default_nettype none

module bus_cycle_arbiter
    import bus_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req,
    input  logic [1:0][1:0]        req_cmd,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             gnt,
    output logic [1:0]             done,
    output logic [DATA_W-1:0]      rdata,
    input  logic                   bus_ready,
    input  logic [DATA_W-1:0]      bus_rdata,
    output logic [ADDR_W-1:0]      addr_bus,
    output logic [DATA_W-1:0]      data_out,
    output logic                   ale,
    output logic                   rd,
    output logic                   wr,
    output logic                   m_io,
    output logic                   busy,
    output logic                   timeout_err
);

`ifdef WAIT_TIMEOUT_EN
    localparam logic c_timeout_en = 1'b1;
`else
    localparam logic c_timeout_en = 1'b0;
`endif

    state_e              state_q, state_d;
    logic [15:0]         wait_cnt_q, wait_cnt_d;
    cmd_e                cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                owner_q, owner_d;
    logic                to_flag_q, to_flag_d;

    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_bus_q, addr_bus_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                ale_q, ale_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                m_io_q, m_io_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;

    logic [1:0]          w_grant;
    logic                w_arb_en;
    logic                w_is_read;
    logic                w_strobe_phase;
    logic                w_wait_expired;

    assign w_arb_en       = (state_q == ST_IDLE);
    assign w_is_read      = cmd_is_read(cmd_q);
    assign w_strobe_phase = (state_q == ST_T2) || (state_q == ST_T3) || (state_q == ST_TW);
    assign w_wait_expired = c_timeout_en && (state_q == ST_TW) && !bus_ready &&
                            (wait_cnt_q == 16'(WAIT_LIMIT - 1));

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (w_arb_en),
        .grant   (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= 16'd0;
            cmd_q         <= MEM_RD;
            addr_q        <= '0;
            wdata_q       <= '0;
            owner_q       <= 1'b0;
            to_flag_q     <= 1'b0;
            gnt_q         <= 2'b00;
            done_q        <= 2'b00;
            rdata_q       <= '0;
            addr_bus_q    <= '0;
            data_out_q    <= '0;
            ale_q         <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            m_io_q        <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            owner_q       <= owner_d;
            to_flag_q     <= to_flag_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            addr_bus_q    <= addr_bus_d;
            data_out_q    <= data_out_d;
            ale_q         <= ale_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            m_io_q        <= m_io_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: if (req != 2'b00) state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                wait_cnt_d = 16'd0;
                state_d    = bus_ready ? ST_T4 : ST_TW;
            end
            ST_TW: begin
                if (bus_ready || w_wait_expired) begin
                    state_d = ST_T4;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_T4:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the current state and registered, so each
    // bus phase becomes visible one cycle after the state is entered.
    always_comb begin
        gnt_d         = 2'b00;
        done_d        = 2'b00;
        ale_d         = 1'b0;
        rd_d          = 1'b0;
        wr_d          = 1'b0;
        busy_d        = (state_q != ST_IDLE);
        timeout_err_d = 1'b0;
        rdata_d       = rdata_q;
        addr_bus_d    = addr_bus_q;
        data_out_d    = data_out_q;
        m_io_d        = m_io_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        owner_d       = owner_q;
        to_flag_d     = to_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (w_grant != 2'b00) begin
                    gnt_d     = w_grant;
                    owner_d   = w_grant[1];
                    cmd_d     = cmd_e'(req_cmd[w_grant[1]]);
                    addr_d    = req_addr[w_grant[1]];
                    wdata_d   = req_wdata[w_grant[1]];
                    to_flag_d = 1'b0;
                end
            end
            ST_T1: begin
                ale_d      = 1'b1;
                addr_bus_d = addr_q;
                data_out_d = wdata_q;
                m_io_d     = cmd_is_mem(cmd_q);
            end
            ST_T4: begin
                done_d        = owner_q ? 2'b10 : 2'b01;
                timeout_err_d = to_flag_q;
            end
            default: ;
        endcase

        if (w_strobe_phase) begin
            rd_d = w_is_read;
            wr_d = !w_is_read;
        end

        if (((state_q == ST_T3) || (state_q == ST_TW)) && bus_ready && w_is_read) begin
            rdata_d = bus_rdata;
        end

        if (w_wait_expired) begin
            to_flag_d = 1'b1;
            rdata_d   = 8'hFF;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign addr_bus    = addr_bus_q;
    assign data_out    = data_out_q;
    assign ale         = ale_q;
    assign rd          = rd_q;
    assign wr          = wr_q;
    assign m_io        = m_io_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

`default_nettype wire

// File: doc/bus_cycle_arbiter.md
BUS_CYCLE_ARBITER -- requirements
Module: bus_cycle_arbiter

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: maximum consecutive wait states before timeout, used only when WAIT_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req  input  2  per-requester request; held high until the matching done pulse.
REQ-005 req_cmd  input  2x2  per-requester command: MEM_RD, MEM_WR, IO_RD, IO_WR (bus_pkg encoding).
REQ-006 req_addr  input  2x20  per-requester address.
REQ-007 req_wdata  input  2x8  per-requester write data.
REQ-008 gnt  output  2  one-hot, one-cycle pulse when a requester is accepted.
REQ-009 done  output  2  one-hot, one-cycle pulse at cycle completion.
REQ-010 rdata  output  8  read data; valid while done is high for a read.
REQ-011 bus_ready  input  1  external ready; low inserts wait states.
REQ-012 bus_rdata  input  8  external read data.
REQ-013 addr_bus  output  20  latched cycle address.
REQ-014 data_out  output  8  write data to bus.
REQ-015 ale, rd, wr, m_io  output  1 each  address latch enable, read strobe, write strobe, 1 = memory / 0 = IO.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 timeout_err  output  1  one-cycle pulse with done on timeout abort.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 States SHALL be IDLE, T1, T2, T3, TW, T4.
REQ-020 IDLE: if any req is high, SHALL select a winner round-robin, latch its cmd/addr/wdata, pulse gnt for that requester, and go to T1; otherwise stay in IDLE.
REQ-021 Round-robin: after reset requester 0 SHALL win a tie; after that the requester not granted last SHALL win a tie.
REQ-022 T1: ale=1, addr_bus=latched address, m_io from cmd, rd=wr=0.
REQ-023 T2: ale=0; rd=1 for reads, or wr=1 with data_out=latched wdata for writes.
REQ-024 T3: bus_ready=1 goes to T4 and captures bus_rdata on reads; bus_ready=0 goes to TW.
REQ-025 TW: strobes held; stays in TW while bus_ready=0; bus_ready=1 captures data and goes to T4.
REQ-026 T4: rd=wr=0, done pulses for the owner, rdata valid, then IDLE.
REQ-027 Minimum transaction is gnt to done in 4 cycles; a new grant is possible in the cycle after T4.
REQ-028 A requester dropping req mid-cycle SHALL NOT abort the cycle; done still pulses.
REQ-029 addr_bus and data_out SHALL hold their values from T1 until the next grant.

Reset
REQ-030 On rst: state=IDLE, RR pointer favours requester 0, and every output (addr_bus, data_out, rdata, gnt, done, ale, rd, wr, m_io, busy, timeout_err) is 0.
REQ-031 Reset mid-cycle SHALL abandon the transaction with no done pulse.

Configuration
REQ-032 Macro WAIT_TIMEOUT_EN.
- Defined: a counter SHALL count TW cycles; when it reaches WAIT_LIMIT, go to T4 with done=1, timeout_err=1, rdata=8'hFF.
- Undefined: TW SHALL wait indefinitely and timeout_err SHALL be tied to 0, keeping the port list identical.

Structure
REQ-033 Package bus_pkg SHALL hold the state enum, the cmd enum (MEM_RD=0, MEM_WR=1, IO_RD=2, IO_WR=3), and constants ADDR_W=20 and DATA_W=8.
REQ-034 Sub-module rr_arbiter2 (2-input round-robin with pointer update on grant) SHALL be instantiated.

Verification
REQ-035 req0 MEM_RD addr 20'h12345, bus_ready=1, bus_rdata=8'hA5 -> gnt0, ale+addr in T1, rd in T2-T3, done0 with rdata=8'hA5 four cycles after gnt.
REQ-036 req1 IO_WR addr 20'h003F8 data 8'h5A -> m_io=0, wr high T2-T3, data_out=8'h5A, done1.
REQ-037 req0 and req1 held continuously -> grants alternate 0,1,0,1 starting with 0.
REQ-038 bus_ready low for 3 cycles after T2 -> exactly 3 TW cycles, done delayed by 3.
REQ-039 WAIT_TIMEOUT_EN defined, WAIT_LIMIT=4, bus_ready stuck at 0 -> 4 TW cycles, then done plus timeout_err, rdata=8'hFF.
REQ-040 rst asserted in TW -> next cycle IDLE with all outputs 0 and no done; pending req granted afterwards to requester 0.
